// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller drives the control lines (master); the datapath drives IR opcode and flags.
interface mips_multicycle_ctrl_if #(
    parameter int OPW   = 6,
    parameter int CNT_W = 32
);
    logic [OPW-1:0]   opcode;
    logic             zero;
    logic             sign;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic [1:0]       reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, sign, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, retired
    );

    modport slave (
        output opcode, zero, sign, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory-ready waits, retired-instruction
// counter and illegal-opcode trap.
module mips_multicycle_ctrl #(
    parameter int OPW       = 6,
    parameter int CNT_W     = 32,
    parameter bit TRAP_HOLD = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [OPW-1:0] OP_R      = 6'b000000;
    localparam logic [OPW-1:0] OP_LW     = 6'b100011;
    localparam logic [OPW-1:0] OP_SW     = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ    = 6'b000100;
    localparam logic [OPW-1:0] OP_J      = 6'b000010;
    localparam logic [OPW-1:0] OP_ORI    = 6'b001101;
    localparam logic [OPW-1:0] OP_BGEZAL = 6'b100111;
    localparam logic [OPW-1:0] OP_JRS    = 6'b010010;
    localparam logic [OPW-1:0] OP_BALV   = 6'b100001;

    typedef enum logic [4:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, JRPC, REXEC, RWB,
        IEXEC, IWB, BRANCH, JUMP, LINK, BLINK, BGEZ, TRAP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    state_t           state, nxt;
    ctrl_t            q;
    logic [CNT_W-1:0] cnt;
    logic             retire;

    // State-determined control word, registered alongside the state it belongs to.
    function automatic ctrl_t outs(input state_t s);
        ctrl_t o;
        o = '0;
        case (s)
            FETCH:  begin o.mem_read = 1'b1; o.alu_src_b = 2'd1; end
            DECODE: o.alu_src_b = 2'd3;
            MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
            MEMRD:  begin o.iord = 1'b1; o.mem_read = 1'b1; end
            MEMWR:  begin o.iord = 1'b1; o.mem_write = 1'b1; end
            MEMWB:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
            JRPC:   begin o.pc_source = 2'd3; o.pc_write = 1'b1; end
            REXEC:  begin o.alu_src_a = 1'b1; o.alu_op = 2'd2; end
            RWB:    begin o.reg_dst = 2'd1; o.reg_write = 1'b1; end
            IEXEC:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 2'd3; end
            IWB:    o.reg_write = 1'b1;
            BRANCH: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'd1;
                o.pc_source = 2'd1; o.pc_write_cond = 1'b1;
            end
            JUMP:   begin o.pc_source = 2'd2; o.pc_write = 1'b1; end
            LINK:   begin o.reg_dst = 2'd2; o.reg_write = 1'b1; end
            BLINK:  begin o.pc_source = 2'd1; o.pc_write = 1'b1; end
            BGEZ:   begin o.alu_src_a = 1'b1; o.pc_source = 2'd1; end
            TRAP:   o.illegal = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   nxt = FETCH;
            FETCH:  if (bus.mem_ready) nxt = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW, OP_JRS: nxt = MEMADR;
                    OP_R:                 nxt = REXEC;
                    OP_ORI:               nxt = IEXEC;
                    OP_BEQ:               nxt = BRANCH;
                    OP_J:                 nxt = JUMP;
                    OP_BGEZAL, OP_BALV:   nxt = LINK;
                    default:              nxt = TRAP;
                endcase
            end
            MEMADR: nxt = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (bus.mem_ready) nxt = (bus.opcode == OP_JRS) ? JRPC : MEMWB;
            MEMWR:  if (bus.mem_ready) nxt = FETCH;
            REXEC:  nxt = RWB;
            IEXEC:  nxt = IWB;
            LINK:   nxt = (bus.opcode == OP_BALV) ? BLINK : BGEZ;
            MEMWB, JRPC, RWB, IWB, BRANCH, JUMP, BLINK, BGEZ: nxt = FETCH;
            TRAP:   nxt = TRAP_HOLD ? TRAP : FETCH;
            default: nxt = IDLE;
        endcase
    end

    // Only completing states count; IDLE->FETCH and TRAP->FETCH do not retire.
    assign retire = (nxt == FETCH) &&
                    (state inside {MEMWR, MEMWB, JRPC, RWB, IWB, BRANCH, JUMP, BLINK, BGEZ});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
        end else begin
            state <= nxt;
            q     <= outs(nxt);
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    // IR/PC load in FETCH and the bgezal PC load are qualified by this cycle's inputs.
    assign bus.ir_write      = (state == FETCH) && bus.mem_ready;
    assign bus.pc_write      = q.pc_write || ((state == FETCH) && bus.mem_ready)
                                          || ((state == BGEZ) && !bus.sign);
    assign bus.pc_write_cond = q.pc_write_cond;
    assign bus.iord          = q.iord;
    assign bus.mem_read      = q.mem_read;
    assign bus.mem_write     = q.mem_write;
    assign bus.mem_to_reg    = q.mem_to_reg;
    assign bus.reg_dst       = q.reg_dst;
    assign bus.reg_write     = q.reg_write;
    assign bus.alu_src_a     = q.alu_src_a;
    assign bus.alu_src_b     = q.alu_src_b;
    assign bus.alu_op        = q.alu_op;
    assign bus.pc_source     = q.pc_source;
    assign bus.illegal       = q.illegal;
    assign bus.retired       = cnt;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction is expanded into its expected
// step list and the controller outputs are compared every cycle.
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_BGEZAL = 6'b100111;
    localparam logic [5:0] OP_JRS    = 6'b010010;
    localparam logic [5:0] OP_BALV   = 6'b100001;

    localparam int K_NORM = 0, K_FETCH = 1, K_BGEZ = 2, K_TRAP = 3;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       illegal;
    } ctl_t;

    typedef struct {
        string nm;
        ctl_t  c;
        bit    mwait;
        int    kind;
        int    reps;
    } step_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ret_exp = '0;
    step_t       plan[$];

    mips_multicycle_ctrl_if #(.OPW(6), .CNT_W(32)) bus ();

    mips_multicycle_ctrl #(.OPW(6), .CNT_W(32), .TRAP_HOLD(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t o;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.iord          = bus.iord;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.ir_write      = bus.ir_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.reg_dst       = bus.reg_dst;
        o.reg_write     = bus.reg_write;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.pc_source     = bus.pc_source;
        o.illegal       = bus.illegal;
        return o;
    endfunction

    task automatic add(input string nm, input ctl_t c, input bit mwait, input int kind, input int reps);
        step_t s;
        s.nm = nm; s.c = c; s.mwait = mwait; s.kind = kind; s.reps = reps;
        plan.push_back(s);
    endtask

    // Reference: the phases an instruction walks through and the controls each one shows.
    task automatic build(input logic [5:0] op);
        ctl_t c;
        plan.delete();
        c = '0; c.mem_read = 1; c.alu_src_b = 1;           add("fetch", c, 1, K_FETCH, 1);
        c = '0; c.alu_src_b = 3;                           add("decode", c, 0, K_NORM, 1);
        case (op)
            OP_LW, OP_SW, OP_JRS: begin
                c = '0; c.alu_src_a = 1; c.alu_src_b = 2;  add("memadr", c, 0, K_NORM, 1);
                if (op == OP_SW) begin
                    c = '0; c.iord = 1; c.mem_write = 1;   add("memwr", c, 1, K_NORM, 1);
                end else begin
                    c = '0; c.iord = 1; c.mem_read = 1;    add("memrd", c, 1, K_NORM, 1);
                    c = '0;
                    if (op == OP_LW) begin c.mem_to_reg = 1; c.reg_write = 1; add("memwb", c, 0, K_NORM, 1); end
                    else begin c.pc_source = 3; c.pc_write = 1; add("jrpc", c, 0, K_NORM, 1); end
                end
            end
            OP_R: begin
                c = '0; c.alu_src_a = 1; c.alu_op = 2;     add("rexec", c, 0, K_NORM, 1);
                c = '0; c.reg_dst = 1; c.reg_write = 1;    add("rwb", c, 0, K_NORM, 1);
            end
            OP_ORI: begin
                c = '0; c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = 3; add("iexec", c, 0, K_NORM, 1);
                c = '0; c.reg_write = 1;                   add("iwb", c, 0, K_NORM, 1);
            end
            OP_BEQ: begin
                c = '0; c.alu_src_a = 1; c.alu_op = 1; c.pc_source = 1; c.pc_write_cond = 1;
                add("branch", c, 0, K_NORM, 1);
            end
            OP_J: begin
                c = '0; c.pc_source = 2; c.pc_write = 1;   add("jump", c, 0, K_NORM, 1);
            end
            OP_BGEZAL, OP_BALV: begin
                c = '0; c.reg_dst = 2; c.reg_write = 1;    add("link", c, 0, K_NORM, 1);
                c = '0; c.pc_source = 1;
                if (op == OP_BALV) begin c.pc_write = 1; add("blink", c, 0, K_NORM, 1); end
                else begin c.alu_src_a = 1; add("bgez", c, 0, K_BGEZ, 1); end
            end
            default: begin
                c = '0; c.illegal = 1;                     add("trap", c, 0, K_TRAP, 10);
            end
        endcase
    endtask

    // fl/ml: low cycles before mem_ready in fetch / data access (-1 random); zs: zero&sign value (-1 random).
    task automatic run_instr(input logic [5:0] op, input int fl, input int ml, input int zs,
                             input bit rst_mid, output int ncyc);
        step_t s;
        ctl_t  e;
        int    lows, k, w;
        bit    mr, sg, zr;
        string tag;
        build(op);
        bus.opcode = op;
        ncyc = 0;
        foreach (plan[i]) begin
            s = plan[i];
            w = (i == 0) ? fl : ml;
            lows = !s.mwait ? 0 : (w < 0) ? int'($urandom_range(0, 3)) : w;
            k = 0;
            forever begin
                @(negedge clk);
                ncyc++;
                zr = (zs < 0) ? bit'($urandom_range(0, 1)) : zs[0];
                sg = (zs < 0) ? bit'($urandom_range(0, 1)) : zs[0];
                mr = s.mwait ? (k >= lows) : bit'($urandom_range(0, 1));
                if (rst_mid && s.mwait && i > 0) mr = 1'b0;
                bus.zero = zr; bus.sign = sg; bus.mem_ready = mr;
                #1;
                e = s.c;
                if (s.kind == K_FETCH) begin e.pc_write = mr; e.ir_write = mr; end
                if (s.kind == K_BGEZ) e.pc_write = ~sg;
                tag = $sformatf("op%b_%s_c%0d", op, s.nm, k);
                check(tag, 32'(obs()), 32'(e));
                check({tag, "_retired"}, bus.retired, ret_exp);
                check({tag, "_rw_excl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
                if (rst_mid && s.mwait && i > 0) begin
                    reset = 1'b1;
                    #1;
                    check("midreset_outs", 32'(obs()), 32'd0);
                    check("midreset_retired", bus.retired, 32'd0);
                    return;
                end
                k++;
                if (s.mwait ? mr : (k >= s.reps)) break;
            end
        end
        if (plan[plan.size()-1].kind != K_TRAP) ret_exp++;
    endtask

    task automatic reset_seq();
        reset = 1'b1;
        ret_exp = '0;
        @(negedge clk);
        #1;
        check("reset_outs", 32'(obs()), 32'd0);
        check("reset_retired", bus.retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] legal [9];
        int n;
        legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI, OP_BGEZAL, OP_JRS, OP_BALV};
        bus.opcode = '0; bus.zero = 1'b0; bus.sign = 1'b0; bus.mem_ready = 1'b0;
        reset_seq();

        run_instr(OP_R, 0, 0, -1, 1'b0, n);      check("rtype_cycles", n, 4);
        run_instr(OP_LW, 0, 3, -1, 1'b0, n);     check("lw_wait3_cycles", n, 8);
        run_instr(OP_BEQ, 0, 0, 1, 1'b0, n);     check("beq_z1_cycles", n, 3);
        run_instr(OP_BEQ, 0, 0, 0, 1'b0, n);     check("beq_z0_cycles", n, 3);
        run_instr(OP_BGEZAL, 0, 0, 1, 1'b0, n);  check("bgezal_s1_cycles", n, 4);
        run_instr(OP_BGEZAL, 0, 0, 0, 1'b0, n);  check("bgezal_s0_cycles", n, 4);
        run_instr(OP_SW, 2, 2, -1, 1'b0, n);     check("sw_cycles", n, 8);
        run_instr(OP_J, 1, 0, -1, 1'b0, n);      check("j_cycles", n, 4);
        run_instr(OP_ORI, 0, 0, -1, 1'b0, n);    check("ori_cycles", n, 4);
        run_instr(OP_JRS, 0, 1, -1, 1'b0, n);    check("jrs_cycles", n, 6);
        run_instr(OP_BALV, 0, 0, -1, 1'b0, n);   check("balv_cycles", n, 4);

        for (int i = 0; i < 40; i++)
            run_instr(legal[$urandom_range(0, 8)], -1, -1, -1, 1'b0, n);

        run_instr(OP_SW, 0, 0, -1, 1'b1, n);
        reset_seq();
        run_instr(OP_R, 0, 0, -1, 1'b0, n);
        run_instr(OP_LW, -1, -1, -1, 1'b0, n);

        run_instr(6'b111111, 0, 0, -1, 1'b0, n); check("trap_cycles", n, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
